// File: rtl/siso_pkg.sv
// Shared types and LTE block-size helpers for the SISO half-iteration scheduler.
package siso_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      LOAD,
      FEED,
      DRAIN,
      NEXT,
      DONE
   } state_e;

   localparam int unsigned BLK_W            = 16;
   localparam int unsigned LTE_K_MIN        = 40;
   localparam int unsigned LTE_K_MAX        = 6144;
   localparam int unsigned TAIL_LEN_DEFAULT = 3;

   // True when k is one of the 188 LTE turbo-code interleaver sizes.
   function automatic logic is_lte_k(input logic [BLK_W-1:0] k);
      logic ok;
      ok = 1'b0;
      if (k >= BLK_W'(LTE_K_MIN) && k <= 16'd512)
         ok = (k[2:0] == 3'd0);
      else if (k >= 16'd528 && k <= 16'd1024)
         ok = (k[3:0] == 4'd0);
      else if (k >= 16'd1056 && k <= 16'd2048)
         ok = (k[4:0] == 5'd0);
      else if (k >= 16'd2112 && k <= BLK_W'(LTE_K_MAX))
         ok = (k[5:0] == 6'd0);
      return ok;
   endfunction

endpackage

// File: rtl/siso_rd_delay.sv
// Aligns the SISO input/a-priori valid strobes with memory read data (RD_LAT deep).
module siso_rd_delay #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_flush,
   input  logic i_valid_in,
   input  logic i_valid_apriori,
   output logic o_valid_in,
   output logic o_valid_apriori,
   output logic o_busy
);

   logic [RD_LAT-1:0] r_vin;
   logic [RD_LAT-1:0] r_vap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vin <= '0;
         r_vap <= '0;
      end else if (i_flush) begin
         r_vin <= '0;
         r_vap <= '0;
      end else begin
         r_vin[0] <= i_valid_in;
         r_vap[0] <= i_valid_apriori;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vin[i] <= r_vin[i-1];
            r_vap[i] <= r_vap[i-1];
         end
      end
   end

   assign o_valid_in      = r_vin[RD_LAT-1];
   assign o_valid_apriori = r_vap[RD_LAT-1];
   // a-priori strobes are a subset of input strobes, so r_vin alone marks occupancy
   assign o_busy          = |r_vin;

endmodule

// File: rtl/siso_halfiter_sched.sv
// Time-shares one SISO core between both LTE constituent decoders, one half-iteration at a time.
module siso_halfiter_sched
   import siso_pkg::*;
#(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned ITER_W   = 4,
   parameter int unsigned TAIL_LEN = TAIL_LEN_DEFAULT,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [BLK_W-1:0]  cfg_blklen,
   input  logic [ITER_W-1:0] cfg_max_iter,
   output logic              cfg_ready,
   input  logic              abort,
   input  logic              early_stop,
   output logic              err_blklen,
   output logic [BLK_W-1:0]  siso_blklen,
   output logic              siso_valid_blklen,
   input  logic              siso_ready,
   output logic              siso_valid_in,
   output logic              siso_valid_apriori,
   input  logic              siso_valid_extrinsic,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_phase,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              dec_sel,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done
);

   state_e              r_state;
   state_e              w_next;
   logic [BLK_W-1:0]    r_k;
   logic [ITER_W-1:0]   r_max_iter;
   logic [ITER_W-1:0]   r_iter;
   logic [ITER_W-1:0]   w_iter_inc;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [ADDR_W-1:0]   r_ext_cnt;
   logic                r_rd_phase;
   logic                r_rd_en;
   logic                r_dec_sel;
   logic                r_vblk;
   logic                r_err;
   logic                r_busy;
   logic                r_done;
   logic                w_accept;
   logic                w_k_ok;
   logic                w_last_rd;
   logic                w_ext_done;
   logic                w_wr;
   logic                w_stop;
   logic                w_flush;
   logic                w_ap_in;
   logic                w_pipe_busy;

   assign w_accept   = (r_state == IDLE) & cfg_valid;
   assign w_k_ok     = is_lte_k(cfg_blklen);
   assign w_last_rd  = r_rd_phase & (BLK_W'(r_rd_addr) == r_k + BLK_W'(TAIL_LEN - 1));
   assign w_ext_done = (BLK_W'(r_ext_cnt) == r_k);
   assign w_wr       = ((r_state == FEED) | (r_state == DRAIN)) & siso_valid_extrinsic
                       & (BLK_W'(r_ext_cnt) < r_k);
   assign w_iter_inc = r_iter + ITER_W'(1);
   assign w_stop     = (w_iter_inc >= r_max_iter) | early_stop;
   assign w_flush    = abort & (r_state != IDLE);
   // tail pairs carry no a-priori information
   assign w_ap_in    = r_rd_en & r_rd_phase & (BLK_W'(r_rd_addr) < r_k);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:     if (cfg_valid && w_k_ok) w_next = WAIT_RDY;
            WAIT_RDY: if (siso_ready) w_next = LOAD;
            LOAD:     w_next = FEED;
            FEED:     if (w_last_rd) w_next = DRAIN;
            DRAIN:    if (w_ext_done && !w_pipe_busy) w_next = NEXT;
            NEXT:     w_next = (r_dec_sel && w_stop) ? DONE : WAIT_RDY;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k        <= '0;
         r_max_iter <= '0;
         r_iter     <= '0;
         r_dec_sel  <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_phase <= 1'b0;
         r_ext_cnt  <= '0;
         r_rd_en    <= 1'b0;
         r_vblk     <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_err   <= w_accept & ~w_k_ok;
         r_vblk  <= (w_next == LOAD);
         r_rd_en <= (w_next == FEED);
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
         if (w_accept && w_k_ok) begin
            r_k        <= cfg_blklen;
            r_max_iter <= (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
            r_dec_sel  <= 1'b0;
            r_iter     <= '0;
         end
         if (r_state == LOAD) begin
            r_rd_addr  <= '0;
            r_rd_phase <= 1'b0;
            r_ext_cnt  <= '0;
         end else begin
            if (r_rd_en) begin
               r_rd_phase <= ~r_rd_phase;
               if (r_rd_phase) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            if (w_wr) r_ext_cnt <= r_ext_cnt + ADDR_W'(1);
         end
         // decoder-2 completion closes a full iteration
         if (r_state == NEXT && !w_flush) begin
            if (!r_dec_sel) begin
               r_dec_sel <= 1'b1;
            end else begin
               r_iter <= w_iter_inc;
               if (!w_stop) r_dec_sel <= 1'b0;
            end
         end
      end
   end

   siso_rd_delay #(
      .RD_LAT (RD_LAT)
   ) u_rd_delay (
      .clk             (clk),
      .rst_n           (rst),
      .i_flush         (w_flush),
      .i_valid_in      (r_rd_en),
      .i_valid_apriori (w_ap_in),
      .o_valid_in      (siso_valid_in),
      .o_valid_apriori (siso_valid_apriori),
      .o_busy          (w_pipe_busy)
   );

   assign cfg_ready         = (r_state == IDLE);
   assign err_blklen        = r_err;
   assign siso_blklen       = r_k;
   assign siso_valid_blklen = r_vblk;
   assign rd_en             = r_rd_en;
   assign rd_addr           = r_rd_addr;
   assign rd_phase          = r_rd_phase;
   assign wr_en             = w_wr;
   assign wr_addr           = r_ext_cnt;
   assign dec_sel           = r_dec_sel;
   assign iter_cnt          = r_iter;
   assign busy              = r_busy;
   assign done              = r_done;

endmodule

// File: tb/tb_siso_halfiter_sched.sv
// Directed bench for siso_halfiter_sched with a simple SISO core stand-in.
module tb_siso_halfiter_sched;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned ITER_W = 4;

   logic              clk;
   logic              rst;
   logic              cfg_valid;
   logic [15:0]       cfg_blklen;
   logic [ITER_W-1:0] cfg_max_iter;
   logic              cfg_ready;
   logic              abort;
   logic              early_stop;
   logic              err_blklen;
   logic [15:0]       siso_blklen;
   logic              siso_valid_blklen;
   logic              siso_ready;
   logic              siso_valid_in;
   logic              siso_valid_apriori;
   logic              siso_valid_extrinsic;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_phase;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              dec_sel;
   logic [ITER_W-1:0] iter_cnt;
   logic              busy;
   logic              done;

   int total;
   int bad;

   // cumulative activity counters kept by the negedge monitor
   int m_rd, m_vin, m_ap, m_blk, m_wr, m_done, m_err;
   int m_exp_wa, m_exp_rd, m_wa_err, m_rd_err;

   siso_halfiter_sched #(
      .ADDR_W   (ADDR_W),
      .ITER_W   (ITER_W),
      .TAIL_LEN (3),
      .RD_LAT   (1)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cfg_valid            (cfg_valid),
      .cfg_blklen           (cfg_blklen),
      .cfg_max_iter         (cfg_max_iter),
      .cfg_ready            (cfg_ready),
      .abort                (abort),
      .early_stop           (early_stop),
      .err_blklen           (err_blklen),
      .siso_blklen          (siso_blklen),
      .siso_valid_blklen    (siso_valid_blklen),
      .siso_ready           (siso_ready),
      .siso_valid_in        (siso_valid_in),
      .siso_valid_apriori   (siso_valid_apriori),
      .siso_valid_extrinsic (siso_valid_extrinsic),
      .rd_en                (rd_en),
      .rd_addr              (rd_addr),
      .rd_phase             (rd_phase),
      .wr_en                (wr_en),
      .wr_addr              (wr_addr),
      .dec_sel              (dec_sel),
      .iter_cnt             (iter_cnt),
      .busy                 (busy),
      .done                 (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      m_rd = 0; m_vin = 0; m_ap = 0; m_blk = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_exp_wa = 0; m_exp_rd = 0; m_wa_err = 0; m_rd_err = 0;
   end

   always @(negedge clk) begin
      if (rst) begin
         if (siso_valid_blklen) begin
            m_blk++;
            m_exp_wa = 0;
            m_exp_rd = 0;
         end
         if (rd_en) begin
            m_rd++;
            if (rd_addr !== ADDR_W'(m_exp_rd / 2) || rd_phase !== m_exp_rd[0]) m_rd_err++;
            m_exp_rd++;
         end
         if (siso_valid_in)      m_vin++;
         if (siso_valid_apriori) m_ap++;
         if (wr_en) begin
            m_wr++;
            if (wr_addr !== ADDR_W'(m_exp_wa)) m_wa_err++;
            m_exp_wa++;
         end
         if (done)       m_done++;
         if (err_blklen) m_err++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int k, input int mi);
      chk("cfg_ready_before_req", int'(cfg_ready), 1);
      cfg_blklen   = 16'(k);
      cfg_max_iter = ITER_W'(mi);
      cfg_valid    = 1'b1;
      step();
      cfg_valid    = 1'b0;
   endtask

   task automatic wait_blk();
      int t;
      t = 0;
      while (siso_valid_blklen !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      chk("blklen_strobe_timeout", int'(t < 100), 1);
   endtask

   // One half-iteration: SISO goes busy after config, optionally streams extrinsics during feed.
   task automatic do_half(input int k, input int n_ext, input int exp_dec, input bit overlap);
      int t, n, exp_wr;
      int b_rd, b_vin, b_ap, b_blk, b_wr;
      bit seen;
      b_rd = m_rd; b_vin = m_vin; b_ap = m_ap; b_blk = m_blk; b_wr = m_wr;
      wait_blk();
      chk("dec_sel", int'(dec_sel), exp_dec);
      chk("siso_blklen", int'(siso_blklen), k);
      siso_ready = 1'b0;
      n = 0; t = 0; seen = 1'b0;
      while (!(seen && !rd_en) && t < 13000) begin
         if (rd_en) seen = 1'b1;
         siso_valid_extrinsic = overlap && rd_en && (n < n_ext);
         if (siso_valid_extrinsic) n++;
         step();
         t++;
      end
      chk("feed_timeout", int'(t < 13000), 1);
      while (n < n_ext) begin
         siso_valid_extrinsic = 1'b1;
         n++;
         step();
      end
      siso_valid_extrinsic = 1'b0;
      step();
      siso_ready = 1'b1;
      exp_wr = (n_ext < k) ? n_ext : k;
      chk("blklen_strobes", m_blk - b_blk, 1);
      chk("rd_en_cycles", m_rd - b_rd, 2 * (k + 3));
      chk("valid_in_cycles", m_vin - b_vin, 2 * (k + 3));
      chk("apriori_cycles", m_ap - b_ap, k);
      chk("wr_en_count", m_wr - b_wr, exp_wr);
      chk("wr_addr_seq_errs", m_wa_err, 0);
      chk("rd_addr_seq_errs", m_rd_err, 0);
   endtask

   task automatic wait_done(input int base, input int exp_iter);
      int t;
      t = 0;
      while (m_done == base && t < 100) begin
         step();
         t++;
      end
      repeat (3) step();
      chk("done_pulses", m_done - base, 1);
      chk("iter_cnt_final", int'(iter_cnt), exp_iter);
      chk("busy_after_done", int'(busy), 0);
      chk("cfg_ready_after_done", int'(cfg_ready), 1);
   endtask

   initial begin
      int bk[4];
      int b, b_blk, b_err;
      bit seen;
      int t;
      total = 0; bad = 0;
      rst = 1'b0; cfg_valid = 1'b0; cfg_blklen = '0; cfg_max_iter = '0;
      abort = 1'b0; early_stop = 1'b0; siso_ready = 1'b1; siso_valid_extrinsic = 1'b0;

      // reset state
      repeat (3) step();
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_iter_cnt", int'(iter_cnt), 0);
      rst = 1'b1;
      step();

      // K=40, one full iteration
      b = m_done;
      req(40, 1);
      do_half(40, 40, 0, 1'b0);
      do_half(40, 40, 1, 1'b0);
      wait_done(b, 1);

      // K=6144, early stop at the end of the second full iteration
      b = m_done;
      req(6144, 3);
      do_half(6144, 6144, 0, 1'b1);
      do_half(6144, 6144, 1, 1'b1);
      do_half(6144, 6144, 0, 1'b1);
      early_stop = 1'b1;
      do_half(6144, 6144, 1, 1'b1);
      wait_done(b, 2);
      early_stop = 1'b0;

      // illegal block sizes
      bk = '{44, 520, 6208, 0};
      b_blk = m_blk; b_err = m_err;
      for (int i = 0; i < 4; i++) begin
         cfg_blklen = 16'(bk[i]);
         cfg_max_iter = ITER_W'(2);
         cfg_valid = 1'b1;
         step();
         cfg_valid = 1'b0;
         chk("err_blklen_pulse", int'(err_blklen), 1);
         chk("err_busy", int'(busy), 0);
         step();
         chk("err_blklen_clear", int'(err_blklen), 0);
      end
      chk("err_no_blklen_strobe", m_blk - b_blk, 0);
      chk("err_pulse_count", m_err - b_err, 4);

      // abort in FEED cycle 100
      b = m_done;
      req(512, 2);
      wait_blk();
      step();
      repeat (99) step();
      chk("abort_pre_rd_en", int'(rd_en), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_valid_in", int'(siso_valid_in), 0);
      chk("abort_valid_apriori", int'(siso_valid_apriori), 0);
      chk("abort_wr_en", int'(wr_en), 0);
      chk("abort_cfg_ready", int'(cfg_ready), 1);
      repeat (5) step();
      chk("abort_no_done", m_done - b, 0);
      b = m_done;
      req(40, 1);
      do_half(40, 40, 0, 1'b0);
      do_half(40, 40, 1, 1'b0);
      wait_done(b, 1);

      // SISO over-delivers extrinsics; max_iter=0 behaves as 1
      b = m_done;
      req(40, 0);
      do_half(40, 45, 0, 1'b0);
      do_half(40, 45, 1, 1'b0);
      wait_done(b, 1);

      // async reset while stuck in DRAIN
      req(40, 1);
      wait_blk();
      siso_ready = 1'b0;
      seen = 1'b0; t = 0;
      while (!(seen && !rd_en) && t < 200) begin
         if (rd_en) seen = 1'b1;
         step();
         t++;
      end
      chk("drain_reach_timeout", int'(t < 200), 1);
      repeat (3) step();
      chk("drain_busy", int'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_cfg_ready", int'(cfg_ready), 1);
      chk("async_rst_rd_en", int'(rd_en), 0);
      chk("async_rst_valid_in", int'(siso_valid_in), 0);
      chk("async_rst_dec_sel", int'(dec_sel), 0);
      chk("async_rst_blklen", int'(siso_blklen), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();

      // SISO not ready for 20 cycles after the request
      b = m_done; b_blk = m_blk;
      siso_ready = 1'b0;
      req(40, 1);
      repeat (20) step();
      chk("not_ready_no_blklen", m_blk - b_blk, 0);
      chk("not_ready_busy", int'(busy), 1);
      siso_ready = 1'b1;
      do_half(40, 40, 0, 1'b0);
      do_half(40, 40, 1, 1'b0);
      wait_done(b, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/siso_halfiter_sched.md
Name: siso_halfiter_sched

Overview:
- Scheduler that time-shares one SISO decoder instance between the two constituent decoders of the LTE turbo decoder.
- Per half-iteration it:
  - configures the SISO block length;
  - sequences channel and a-priori memory reads into the SISO input stream;
  - generates write addresses for the returned extrinsic values;
  - decides whether to continue, stop early or finish.
- Sits between the decode-request interface and the SISO core. Interleaved address mapping is external and selected by dec_sel.

Parameters:
- ADDR_W, 13: pair-index / memory address width (covers K+TAIL_LEN ≤ 6147).
- ITER_W, 4: width of max-iteration and iteration-count fields.
- TAIL_LEN, 3: trellis termination pairs appended per constituent decoder.
- RD_LAT, 1: memory read latency in cycles; valid strobes to the SISO are delayed by this amount.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  decode request
- cfg_blklen  in  16  block size K
- cfg_max_iter  in  ITER_W  full iterations allowed (0 treated as 1)
- cfg_ready  out  1  request accepted when cfg_valid&cfg_ready
- abort  in  1  cancel current decode
- early_stop  in  1  stop criterion met (external CRC/compare)
- err_blklen  out  1  one-cycle pulse: rejected K
- siso_blklen  out  16  K to SISO
- siso_valid_blklen  out  1  one-cycle config strobe
- siso_ready  in  1  SISO idle/ready
- siso_valid_in  out  1  channel word valid to SISO
- siso_valid_apriori  out  1  a-priori word valid to SISO
- siso_valid_extrinsic  in  1  extrinsic output valid from SISO
- rd_en  out  1  channel/a-priori memory read
- rd_addr  out  ADDR_W  pair index k
- rd_phase  out  1  0 = systematic word, 1 = parity word
- wr_en  out  1  extrinsic memory write
- wr_addr  out  ADDR_W  extrinsic index 0..K-1
- dec_sel  out  1  0 = decoder 1 (natural), 1 = decoder 2 (interleaved)
- iter_cnt  out  ITER_W  completed full iterations
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except cfg_ready=1. cfg_ready is combinational (state==IDLE).
- Legal K (LTE):
  - 40..512 step 8;
  - 528..1024 step 16;
  - 1056..2048 step 32;
  - 2112..6144 step 64.
- IDLE, on cfg_valid (the cfg_ready=1 handshake cycle):
  - K illegal → err_blklen pulse next cycle; stay IDLE.
  - K legal → latch K and max_iter; dec_sel=0; iter_cnt=0; go WAIT_RDY.
- WAIT_RDY:
  - Hold while siso_ready=0.
  - When siso_ready=1 → LOAD.
- LOAD:
  - siso_blklen=K; siso_valid_blklen=1 for exactly this cycle.
  - Clear read counter, extrinsic counter and wr_addr; → FEED.
- FEED (first cycle immediately after LOAD):
  - rd_en=1 every cycle for 2·(K+TAIL_LEN) cycles.
  - rd_addr = k, rd_phase alternates 0,1 per k.
  - siso_valid_in = rd_en delayed RD_LAT.
  - siso_valid_apriori = (rd_en & rd_phase & k<K) delayed RD_LAT. No a-priori for tail pairs.
  - After the last read → DRAIN.
- Extrinsic capture (in FEED and DRAIN alike):
  - Each siso_valid_extrinsic with count<K → wr_en=1 same cycle (combinational), wr_addr=count, count+1.
  - Strobes beyond K are ignored (no wr_en).
- DRAIN:
  - Wait until count==K and the RD_LAT pipe is empty → NEXT.
  - If count already reached K during FEED, DRAIN still lasts ≥1 cycle.
- NEXT (one cycle):
  - dec_sel=0 → dec_sel=1; → WAIT_RDY.
  - dec_sel=1 → iter_cnt+1. If iter_cnt+1 ≥ max_iter or early_stop=1 (sampled this cycle) → DONE; else dec_sel=0 → WAIT_RDY.
- DONE:
  - done=1 for one cycle; → IDLE.
  - iter_cnt holds its final value until the next accepted request.
- abort (any non-IDLE state):
  - Next cycle state=IDLE; rd_en, wr_en, SISO strobes and delay pipe cleared.
  - No done pulse.
  - abort in IDLE is ignored.
  - abort takes priority over every other transition.
- cfg_valid while busy: ignored (cfg_ready=0).
- All counters are ADDR_W wide and never wrap for legal K.

Decomposition:
- siso_pkg:
  - state enum (IDLE, WAIT_RDY, LOAD, FEED, DRAIN, NEXT, DONE);
  - LTE_K_MIN=40, LTE_K_MAX=6144, TAIL_LEN default;
  - function is_lte_k(k).
- One sub-module is natural: siso_rd_delay, the RD_LAT-deep valid shift register with synchronous flush, carrying siso_valid_in and siso_valid_apriori.

Test Plan:
- K=40, max_iter=1, RD_LAT=1, SISO model returns 40 extrinsics after feed → two half-iterations, each with:
  - exactly one siso_valid_blklen;
  - 86 rd_en cycles;
  - 40 siso_valid_apriori;
  - 40 wr_en with wr_addr 0..39.
  - Then: dec_sel 0→1, done pulse, iter_cnt=1.
- K=6144, max_iter=3, early_stop asserted at NEXT of iteration 2 → done after 4 half-iterations, iter_cnt=2.
- cfg_blklen ∈ {44, 520, 6208, 0} → err_blklen pulse each; busy stays 0; no SISO strobes.
- K=512, abort in cycle 100 of FEED → IDLE next cycle; all strobes 0; no done. New request K=40 then completes normally.
- SISO emits 45 extrinsics for K=40 → 40 wr_en only; scheduler advances normally.
- rst deasserted→asserted mid-DRAIN → outputs zero immediately (async), cfg_ready=1; siso_ready held 0 for 20 cycles after a request → no siso_valid_blklen until siso_ready=1.
